core_sequencer: RTL
===================

# core_sequencer

Parametrised multi-cycle control sequencer for the next-generation core. It replaces the single-cycle assumption that every memory answers in zero cycles: it owns the PC, the instruction register and the write-back strobe, and steps each instruction through FETCH → EXEC → (MEM) → WB. Instruction and data memory use req/ack handshakes with arbitrary wait states and a bus-timeout watchdog. It sits between the memory ports and the existing decoder/datapath/ALU, which stay combinational on `ir`.

## Interface
- `XLEN`, 32: data/instruction width
- `ADDR_W`, 32: PC and memory address width
- `PC_STEP`, 4: sequential PC increment
- `RESET_PC`, 0: PC after reset
- `TIMEOUT`, 15: max wait cycles on a handshake before bus error (≥1)

- `Clk`  in  1  sole clock, rising edge
- `Reset`  in  1  synchronous, active-high
- `imem_req` / `imem_addr`  out  1 / ADDR_W  fetch request, address = `pc`
- `imem_ack` / `imem_rdata`  in  1 / XLEN  fetch complete, instruction word
- `ir`  out  XLEN  latched instruction, drives the decoder
- `dec_load`, `dec_store`, `dec_reg_we`, `dec_halt`, `dec_err`  in  1 each  decoder outputs for `ir`
- `br_taken` / `br_target`  in  1 / ADDR_W  branch decision and target from the ALU/flags
- `alu_result` / `store_data`  in  XLEN each  memory address / result, store value
- `dmem_req`, `dmem_we`  out  1 each  data request, write enable
- `dmem_addr` / `dmem_wdata`  out  ADDR_W / XLEN  registered address and write data
- `dmem_ack` / `dmem_rdata`  in  1 / XLEN  data complete, load data
- `reg_we` / `wb_data`  out  1 / XLEN  register-bank write strobe and value
- `pc`  out  ADDR_W  current instruction address
- `decode_error`  out  2  00 running, 01 halted, 10 illegal instruction, 11 bus timeout
- `retired`  out  32  retired-instruction counter

## Operation
- States: FETCH, EXEC, MEM, WB, HALT, ERROR. Moore outputs: `imem_req` = (FETCH), `dmem_req` = (MEM), `reg_we` = (WB && wb_en_q).
- FETCH: hold `imem_req`. On `imem_ack`, capture `imem_rdata` into `ir` → EXEC.
- EXEC, 1 cycle. Priority: `dec_err` → ERROR (code 10); `dec_halt` → HALT (01); `dec_load|dec_store` → MEM; else → WB.
  - Always latch `br_taken`/`br_target`, `alu_result` into `dmem_addr`/result reg, `store_data` into `dmem_wdata`, `dec_store` into `dmem_we`, `dec_reg_we && !dec_store` into wb_en_q.
- MEM: hold `dmem_req` and stable address/data/we. On `dmem_ack`: a load captures `dmem_rdata` into the result reg → WB.
- WB, 1 cycle: `wb_data` = result reg; `reg_we` pulses if wb_en_q. `pc` ← br_taken_q ? br_target_q : `pc`+`PC_STEP`, modulo 2^ADDR_W (wraps). `retired` +1, wraps → FETCH.
- Watchdog: counter clears on entry to FETCH/MEM and increments each cycle without ack. Once it equals `TIMEOUT` with no ack → ERROR (11). An ack in that same cycle wins.
- HALT and ERROR are absorbing until `Reset`. `decode_error` holds its code, and no req is asserted.
- An ack seen while the matching req is low is ignored.

## Timing
- Reset (edge that samples `Reset`=1): state FETCH, `pc`=`imem_addr`=`RESET_PC`. All other outputs 0, except `imem_req`=1 in the following cycle.
- Reset mid-handshake drops the outstanding req after that edge. A late ack is ignored unless it coincides with the new FETCH req.
- An ack may arrive in the same cycle as req assertion (zero wait). The req deasserts the cycle after ack.
- Minimum latency: ALU op 3 cycles (FETCH, EXEC, WB); load/store 4. Each wait cycle adds 1.
- `pc` and `imem_addr` change only on the WB→FETCH edge. `ir` changes only on fetch ack.

## Structure
- Package `core_seq_pkg`: state enum, `decode_error` codes (ERR_RUN, ERR_HALT, ERR_ILLEGAL, ERR_BUS).
- Sub-module `handshake_watchdog`: parametrised on `TIMEOUT`; inputs clear/active/ack; output `expired`. Shared by the FETCH and MEM waits.

## Test plan
- Zero-wait memories, `RESET_PC`=0, three ALU ops with `dec_reg_we`=1 → `pc` 0,4,8,12 at 3-cycle spacing; `reg_we` one cycle each; `retired`=3.
- Load at `alu_result`=0x100, `dmem_ack` after 2 waits, rdata 0xDEADBEEF → `wb_data`=0xDEADBEEF, `reg_we`=1, 6 cycles total. Store → `dmem_we`=1, `reg_we`=0.
- `br_taken`=1, `br_target`=0x40 → next `imem_addr`=0x40. `pc`=2^ADDR_W−4 with no branch → wraps to 0.
- `imem_ack` withheld with `TIMEOUT`=15 → ERROR on the 15th wait cycle, `decode_error`=11, reqs low thereafter. Ack on exactly that cycle → normal EXEC.
- `dec_halt` → `decode_error`=01, no further req. `dec_err` → 10. `Reset` pulse → FETCH at `RESET_PC`, `retired`=0.
- `Reset` asserted mid-MEM wait → `dmem_req` low next cycle, `imem_req`=1. A stray `dmem_ack` after reset causes no write-back.

Source files
------------

// File: rtl/core_seq_pkg.sv
// Shared state encodings and status codes for the multi-cycle core sequencer.
package core_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_FETCH = 3'd0;
  localparam state_t S_EXEC  = 3'd1;
  localparam state_t S_MEM   = 3'd2;
  localparam state_t S_WB    = 3'd3;
  localparam state_t S_HALT  = 3'd4;
  localparam state_t S_ERROR = 3'd5;

  typedef logic [1:0] err_t;

  localparam err_t ERR_RUN     = 2'b00;
  localparam err_t ERR_HALT    = 2'b01;
  localparam err_t ERR_ILLEGAL = 2'b10;
  localparam err_t ERR_BUS     = 2'b11;

endpackage

// File: rtl/core_sequencer_if.sv
// Memory, decoder and write-back signals between the sequencer and the rest of the core.
interface core_sequencer_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [XLEN-1:0]   imem_rdata;
  logic [XLEN-1:0]   ir;
  logic              dec_load;
  logic              dec_store;
  logic              dec_reg_we;
  logic              dec_halt;
  logic              dec_err;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic [XLEN-1:0]   alu_result;
  logic [XLEN-1:0]   store_data;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [XLEN-1:0]   dmem_wdata;
  logic              dmem_ack;
  logic [XLEN-1:0]   dmem_rdata;
  logic              reg_we;
  logic [XLEN-1:0]   wb_data;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        decode_error;
  logic [31:0]       retired;

  modport master (
    output imem_req, imem_addr, ir, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           reg_we, wb_data, pc, decode_error, retired,
    input  imem_ack, imem_rdata, dec_load, dec_store, dec_reg_we, dec_halt, dec_err,
           br_taken, br_target, alu_result, store_data, dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, ir, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           reg_we, wb_data, pc, decode_error, retired,
    output imem_ack, imem_rdata, dec_load, dec_store, dec_reg_we, dec_halt, dec_err,
           br_taken, br_target, alu_result, store_data, dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/handshake_watchdog.sv
// Counts wait cycles of an outstanding req; expired flags the TIMEOUT-th wait cycle with no ack.
module handshake_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic active,
  input  logic ack,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of wait cycles already elapsed before this one.
  assign expired = active && !ack && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (active && !ack && !expired)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer owning pc, ir and the write-back strobe,
// with req/ack memory handshakes guarded by a bus-timeout watchdog.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int                XLEN     = 32,
  parameter int                ADDR_W   = 32,
  parameter int                PC_STEP  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input logic            Clk,
  input logic            Reset,
  core_sequencer_if.master bus
);
  state_t            state_q, state_d;
  err_t              err_q, err_d;
  logic [ADDR_W-1:0] pc_q, pc_d, tgt_q, tgt_d, addr_q, addr_d;
  logic [XLEN-1:0]   ir_q, ir_d, res_q, res_d, wdata_q, wdata_d;
  logic              we_q, we_d, wb_en_q, wb_en_d, br_q, br_d;
  logic [31:0]       ret_q, ret_d;
  logic              wd_clear, wd_ack, wd_expired;

  assign wd_clear = !(state_q == S_FETCH || state_q == S_MEM);
  assign wd_ack   = (state_q == S_FETCH) ? bus.imem_ack : bus.dmem_ack;

  handshake_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (Clk),
    .rst     (Reset),
    .clear   (wd_clear),
    .active  (!wd_clear),
    .ack     (wd_ack),
    .expired (wd_expired)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    res_d   = res_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    wb_en_d = wb_en_q;
    br_d    = br_q;
    ret_d   = ret_q;
    case (state_q)
      S_FETCH: begin
        if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          state_d = S_EXEC;
        end else if (wd_expired) begin
          err_d   = ERR_BUS;
          state_d = S_ERROR;
        end
      end
      S_EXEC: begin
        br_d    = bus.br_taken;
        tgt_d   = bus.br_target;
        addr_d  = bus.alu_result[ADDR_W-1:0];
        res_d   = bus.alu_result;
        wdata_d = bus.store_data;
        we_d    = bus.dec_store;
        wb_en_d = bus.dec_reg_we && !bus.dec_store;
        if (bus.dec_err) begin
          err_d   = ERR_ILLEGAL;
          state_d = S_ERROR;
        end else if (bus.dec_halt) begin
          err_d   = ERR_HALT;
          state_d = S_HALT;
        end else if (bus.dec_load || bus.dec_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (bus.dmem_ack) begin
          if (!we_q) res_d = bus.dmem_rdata;
          state_d = S_WB;
        end else if (wd_expired) begin
          err_d   = ERR_BUS;
          state_d = S_ERROR;
        end
      end
      S_WB: begin
        pc_d    = br_q ? tgt_q : pc_q + ADDR_W'(PC_STEP);
        ret_d   = ret_q + 32'd1;
        state_d = S_FETCH;
      end
      default: ;
    endcase
  end

  // HALT/ERROR fall into the default arm above and hold everything until Reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_FETCH;
      err_q   <= ERR_RUN;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      addr_q  <= '0;
      ir_q    <= '0;
      res_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      wb_en_q <= 1'b0;
      br_q    <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      res_q   <= res_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      wb_en_q <= wb_en_d;
      br_q    <= br_d;
      ret_q   <= ret_d;
    end
  end

  assign bus.imem_req     = (state_q == S_FETCH);
  assign bus.imem_addr    = pc_q;
  assign bus.pc           = pc_q;
  assign bus.ir           = ir_q;
  assign bus.dmem_req     = (state_q == S_MEM);
  assign bus.dmem_we      = we_q;
  assign bus.dmem_addr    = addr_q;
  assign bus.dmem_wdata   = wdata_q;
  assign bus.reg_we       = (state_q == S_WB) && wb_en_q;
  assign bus.wb_data      = res_q;
  assign bus.decode_error = err_q;
  assign bus.retired      = ret_q;
endmodule
